// File: rtl/zigzag_pkg.sv
// Shared constants for the zigzag reorder stage: coefficient geometry and
// the JPEG zigzag scan table mapping scan position to raster index.
package zigzag_pkg;

    localparam int COEF_W         = 8;
    localparam int COEFS_PER_BEAT = 8;
    localparam int ROWS_PER_BLOCK = 8;
    localparam int BEAT_W         = COEF_W * COEFS_PER_BEAT;
    localparam int BLOCK_W        = BEAT_W * ROWS_PER_BLOCK;

    typedef logic [BEAT_W-1:0]  beat_t;
    typedef logic [BLOCK_W-1:0] block_t;

    // Entry p holds the raster index (row*8+col) of zigzag scan position p.
    localparam logic [5:0] ZZ_ORDER [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zzIndex(input logic [2:0] beat, input logic [2:0] lane);
        return ZZ_ORDER[{beat, lane}];
    endfunction

endpackage

// File: rtl/zigzag_reorder_if.sv
// Row-in / zigzag-beat-out stream bundle. The slave modport is the reorder
// block itself; the master modport is whatever feeds and drains it.
interface zigzag_reorder_if;
    import zigzag_pkg::*;

    logic  in_valid;
    logic  in_ready;
    beat_t in_row;
    logic  out_valid;
    logic  out_ready;
    beat_t out_row;
    logic  out_sob;
    logic  out_eob;

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_row, out_sob, out_eob
    );

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_row, out_sob, out_eob
    );

endinterface

// File: rtl/zigzag_beat_mux.sv
// Combinational selector: picks the eight coefficients of zigzag beat
// beat_i out of a raster-ordered block image (row 0 / col 0 in the MSBs).
module zigzag_beat_mux
    import zigzag_pkg::*;
(
    input  block_t     block_i,
    input  logic [2:0] beat_i,
    output beat_t      beat_o
);

    for (genvar lane = 0; lane < COEFS_PER_BEAT; lane++) begin : g_lane
        localparam logic [2:0] LANE = 3'(lane);

        logic [5:0] rasterIdx;
        logic [8:0] bitBase;

        assign rasterIdx = zzIndex(beat_i, LANE);
        // Raster index 0 sits at the top of the image, so its LSB offset is (63-idx)*8.
        assign bitBase   = {~rasterIdx, 3'b000};
        assign beat_o[(COEFS_PER_BEAT-1-lane)*COEF_W +: COEF_W] = block_i[bitBase +: COEF_W];
    end

endmodule

// File: rtl/zigzag_reorder.sv
// Ping-pong 8x8 block buffer: raster rows fill one bank while the other
// bank drains as eight zigzag-ordered beats toward the RLE stage.
module zigzag_reorder
    import zigzag_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    zigzag_reorder_if.slave   bus
);

    beat_t      bank_q [2][ROWS_PER_BLOCK];
    logic [1:0] full_q,   full_d;

    logic       wrBank_q, wrBank_d;
    logic [2:0] wrRow_q,  wrRow_d;
    logic       rdBank_q, rdBank_d;
    logic [2:0] rdBeat_q, rdBeat_d;

    logic       outValid_q, outValid_d;
    beat_t      outRow_q,   outRow_d;
    logic       outSob_q,   outSob_d;
    logic       outEob_q,   outEob_d;

    logic       accept;
    logic       load;
    block_t     rdImage;
    beat_t      zzBeat;

    assign bus.in_ready = !full_q[wrBank_q];
    assign accept       = bus.in_valid && bus.in_ready;
    // A beat may be loaded when the output register is empty or being consumed.
    assign load         = full_q[rdBank_q] && (!outValid_q || bus.out_ready);

    for (genvar r = 0; r < ROWS_PER_BLOCK; r++) begin : g_image
        assign rdImage[(ROWS_PER_BLOCK-1-r)*BEAT_W +: BEAT_W] = bank_q[rdBank_q][r];
    end

    zigzag_beat_mux u_beat_mux (
        .block_i (rdImage),
        .beat_i  (rdBeat_q),
        .beat_o  (zzBeat)
    );

    always_comb begin
        full_d     = full_q;
        wrBank_d   = wrBank_q;
        wrRow_d    = wrRow_q;
        rdBank_d   = rdBank_q;
        rdBeat_d   = rdBeat_q;
        outValid_d = outValid_q;
        outRow_d   = outRow_q;
        outSob_d   = outSob_q;
        outEob_d   = outEob_q;

        if (accept) begin
            wrRow_d = wrRow_q + 3'd1;
            if (wrRow_q == 3'd7) begin
                full_d[wrBank_q] = 1'b1;
                wrBank_d         = ~wrBank_q;
            end
        end

        // Set and clear always hit different banks: writes target only a
        // non-full bank, reads only a full one.
        if (load) begin
            outRow_d   = zzBeat;
            outSob_d   = (rdBeat_q == 3'd0);
            outEob_d   = (rdBeat_q == 3'd7);
            outValid_d = 1'b1;
            rdBeat_d   = rdBeat_q + 3'd1;
            if (rdBeat_q == 3'd7) begin
                full_d[rdBank_q] = 1'b0;
                rdBank_d         = ~rdBank_q;
            end
        end else if (bus.out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q     <= '0;
            wrBank_q   <= 1'b0;
            wrRow_q    <= '0;
            rdBank_q   <= 1'b0;
            rdBeat_q   <= '0;
            outValid_q <= 1'b0;
            outRow_q   <= '0;
            outSob_q   <= 1'b0;
            outEob_q   <= 1'b0;
        end else begin
            full_q     <= full_d;
            wrBank_q   <= wrBank_d;
            wrRow_q    <= wrRow_d;
            rdBank_q   <= rdBank_d;
            rdBeat_q   <= rdBeat_d;
            outValid_q <= outValid_d;
            outRow_q   <= outRow_d;
            outSob_q   <= outSob_d;
            outEob_q   <= outEob_d;
        end
    end

    // Bank contents are never reset; the full flags alone decide what is live.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_q[wrBank_q][wrRow_q] <= bus.in_row;
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.out_row   = outRow_q;
    assign bus.out_sob   = outSob_q;
    assign bus.out_eob   = outEob_q;

endmodule

// File: tb/tb_zigzag_reorder.sv
// Self-checking bench for zigzag_reorder: a diagonal-walk zigzag model fills
// a scoreboard of expected beats that a negedge monitor compares against.
module tb_zigzag_reorder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    zigzag_reorder_if bus ();

    zigzag_reorder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cycleCnt = 0;

    int          zzRef [64];
    logic [63:0] modelRows [8];
    int          modelRowCnt = 0;

    logic [65:0] expQ [$];
    logic [65:0] obsQ [$];
    int          obsCycles [$];

    int stallCnt        = 0;
    int lastAcceptCycle = 0;
    int row8Cycle       = 0;
    bit randReady       = 1'b0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Build the scan order by walking the anti-diagonals, independent of any table.
    function automatic void buildZz();
        int r = 0;
        int c = 0;
        for (int i = 0; i < 64; i++) begin
            zzRef[i] = r * 8 + c;
            if (((r + c) % 2) == 0) begin
                if (c == 7)      r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7)      c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [65:0] actual, input logic [65:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic logic [65:0] obsAt(input int i);
        if (i < obsQ.size()) return obsQ[i];
        return '1;
    endfunction

    task automatic pushBlock();
        for (int k = 0; k < 8; k++) begin
            logic [63:0] beat;
            beat = '0;
            for (int j = 0; j < 8; j++) begin
                int idx;
                int r;
                int c;
                idx = zzRef[8 * k + j];
                r   = idx / 8;
                c   = idx % 8;
                beat[(7 - j) * 8 +: 8] = modelRows[r][(7 - c) * 8 +: 8];
            end
            expQ.push_back({(k == 0), (k == 7), beat});
        end
    endtask

    task automatic applyStimulus(input logic [63:0] row);
        bit acc      = 1'b0;
        bit timedOut = 1'b0;
        int guard    = 0;
        bus.in_valid = 1'b1;
        bus.in_row   = row;
        while (!acc && !timedOut) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                stallCnt++;
                guard++;
                if (guard >= 3000) begin
                    checkOutput("in_ready_timeout", 66'd0, 66'd1);
                    timedOut = 1'b1;
                end
            end
        end
        bus.in_valid = 1'b0;
        if (acc) begin
            lastAcceptCycle          = cycleCnt;
            modelRows[modelRowCnt]   = row;
            modelRowCnt++;
            if (modelRowCnt == 8) begin
                pushBlock();
                modelRowCnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain();
        int g = 0;
        while ((expQ.size() != 0 || bus.out_valid) && g < 4000) begin
            @(posedge clk);
            #1;
            g++;
        end
        checkOutput("drain_pending", 66'(expQ.size()), 66'd0);
    endtask

    function automatic logic [63:0] indexRow(input int r);
        logic [63:0] row;
        for (int c = 0; c < 8; c++) row[(7 - c) * 8 +: 8] = 8'(r * 8 + c);
        return row;
    endfunction

    // Monitor: every consumed beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            logic [65:0] obs;
            obs = {bus.out_sob, bus.out_eob, bus.out_row};
            obsQ.push_back(obs);
            obsCycles.push_back(cycleCnt);
            checkOutput("beat_expected", 66'(expQ.size() != 0), 66'd1);
            if (expQ.size() != 0) begin
                checkOutput("beat", obs, expQ.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
    end

    logic [63:0] rleRows [8];

    initial begin
        buildZz();
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        idle(3);
        reset = 1'b0;

        @(negedge clk);
        checkOutput("reset_out_valid", 66'(bus.out_valid), 66'd0);
        checkOutput("reset_out_row",   66'(bus.out_row),   66'd0);
        checkOutput("reset_out_sob",   66'(bus.out_sob),   66'd0);
        checkOutput("reset_out_eob",   66'(bus.out_eob),   66'd0);
        checkOutput("reset_in_ready",  66'(bus.in_ready),  66'd1);
        @(posedge clk);
        #1;

        $display("[TB] index block");
        obsQ.delete();
        obsCycles.delete();
        for (int r = 0; r < 8; r++) applyStimulus(indexRow(r));
        row8Cycle = lastAcceptCycle;
        waitDrain();
        checkOutput("index_count", 66'(obsQ.size()), 66'd8);
        checkOutput("index_beat0", obsAt(0), {2'b10, 64'h00_01_08_10_09_02_03_0A});
        checkOutput("index_beat7", obsAt(7), {2'b01, 64'h35_3C_3D_36_2F_37_3E_3F});
        checkOutput("index_latency", 66'(obsCycles.size() > 0 ? obsCycles[0] - row8Cycle : -1), 66'd1);

        $display("[TB] RLE sample block");
        rleRows[0] = 64'h42_04_00_00_0D_00_00_00;
        rleRows[1] = 64'h00_0C_00_03_01_02_00_00;
        rleRows[2] = 64'hF2_00_00_00_00_70_07_00;
        rleRows[3] = 64'h0B_FF_00_00_00_00_00_00;
        rleRows[4] = 64'h01_FF_00_00_0D_00_00_00;
        rleRows[5] = 64'h00_05_02_00_01_00_00_00;
        rleRows[6] = 64'h00_00_00_00_00_00_00_07;
        rleRows[7] = 64'h00_00_00_00_00_00_00_00;
        obsQ.delete();
        for (int r = 0; r < 8; r++) applyStimulus(rleRows[r]);
        waitDrain();
        checkOutput("rle_beat0", obsAt(0), {2'b10, 64'h42_04_00_F2_0C_00_00_00});
        checkOutput("rle_beat7", obsAt(7), {2'b01, 64'h00_00_00_00_00_07_00_00});

        $display("[TB] three back-to-back blocks");
        obsQ.delete();
        obsCycles.delete();
        stallCnt = 0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus({$urandom, $urandom});
            if (i == 7) row8Cycle = lastAcceptCycle;
        end
        waitDrain();
        checkOutput("b2b_stalls", 66'(stallCnt), 66'd0);
        checkOutput("b2b_count", 66'(obsQ.size()), 66'd24);
        checkOutput("b2b_contiguous", 66'(obsCycles.size() == 24 ? obsCycles[23] - obsCycles[0] : -1), 66'd23);
        checkOutput("b2b_latency", 66'(obsCycles.size() > 0 ? obsCycles[0] - row8Cycle : -1), 66'd1);

        $display("[TB] stall with both banks full");
        obsQ.delete();
        bus.out_ready = 1'b0;
        stallCnt = 0;
        for (int i = 0; i < 16; i++) applyStimulus({$urandom, $urandom});
        checkOutput("stall_fill_stalls", 66'(stallCnt), 66'd0);
        @(negedge clk);
        checkOutput("stall_in_ready", 66'(bus.in_ready), 66'd0);
        checkOutput("stall_out_valid", 66'(bus.out_valid), 66'd1);
        checkOutput("stall_hold_beat0", {bus.out_sob, bus.out_eob, bus.out_row}, expQ[0]);
        idle(5);
        @(negedge clk);
        checkOutput("stall_hold_later", {bus.out_sob, bus.out_eob, bus.out_row}, expQ[0]);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        waitDrain();
        checkOutput("stall_count", 66'(obsQ.size()), 66'd16);

        $display("[TB] reset mid-block");
        for (int i = 0; i < 5; i++) applyStimulus({$urandom, $urandom});
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        modelRowCnt = 0;
        expQ.delete();
        obsQ.delete();
        @(negedge clk);
        checkOutput("rst_mid_in_ready", 66'(bus.in_ready), 66'd1);
        checkOutput("rst_mid_out_valid", 66'(bus.out_valid), 66'd0);
        @(posedge clk);
        #1;
        for (int r = 0; r < 8; r++) applyStimulus(indexRow(r));
        waitDrain();
        idle(10);
        checkOutput("rst_mid_count", 66'(obsQ.size()), 66'd8);
        checkOutput("rst_mid_beat0", obsAt(0), {2'b10, 64'h00_01_08_10_09_02_03_0A});

        $display("[TB] random traffic, 50 blocks");
        obsQ.delete();
        randReady = 1'b1;
        for (int b = 0; b < 50; b++) begin
            for (int r = 0; r < 8; r++) begin
                idle($urandom_range(0, 2));
                applyStimulus({$urandom, $urandom});
            end
        end
        randReady = 1'b0;
        idle(1);
        bus.out_ready = 1'b1;
        waitDrain();
        checkOutput("random_count", 66'(obsQ.size()), 66'd400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
